sext_queue: RTL and testbench
=============================

SEXT_QUEUE -- requirements
Module: sext_queue

Interface
REQ-001: The block SHALL have parameter IN_NBITS, default 8, giving the input data width (>= 1).
REQ-002: The block SHALL have parameter OUT_NBITS, default 32, giving the output data width (>= IN_NBITS).
REQ-003: The block SHALL have parameter DEPTH, default 2, giving the result-queue entry count (>= 1, any integer, not only powers of two).
REQ-004: Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005: Port reset, input, 1 bit: synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-006: Port in_val, input, 1 bit: input transaction valid.
REQ-007: Port in_rdy, output, 1 bit: block can accept an input transaction.
REQ-008: Port in_, input, IN_NBITS: value to extend.
REQ-009: Port in_mode, input, 1 bit: 0 = zero-extend, 1 = sign-extend; sampled with in_.
REQ-010: Port out_val, output, 1 bit: queue head valid.
REQ-011: Port out_rdy, input, 1 bit: consumer accepts the head.
REQ-012: Port out, output, OUT_NBITS: extended result at the queue head.
REQ-013: Port count, output, clog2(DEPTH+1) bits: number of occupied entries.

Function
REQ-014: An input transfer SHALL occur on a rising edge where in_val && in_rdy && reset==1; an output transfer SHALL occur where out_val && out_rdy && reset==1.
REQ-015: On an input transfer the block SHALL enqueue out[IN_NBITS-1:0]=in_, upper bits = in_[IN_NBITS-1] if in_mode==1, else 0.
REQ-016: When IN_NBITS==OUT_NBITS, the result SHALL equal in_ unchanged in both modes.
REQ-017: Extension SHALL be computed at enqueue time; later changes to in_/in_mode SHALL NOT affect stored entries.
REQ-018: in_rdy SHALL be combinationally (count < DEPTH); no dependence on out_rdy (no full-pass-through).
REQ-019: out_val SHALL be combinationally (count != 0); out SHALL present the oldest entry; out SHALL be 0 when count==0.
REQ-020: Latency SHALL be exactly one cycle: data accepted at edge N is visible on out/out_val after edge N; no combinational in_-to-out bypass when empty.
REQ-021: Ordering SHALL be strict FIFO; no entry dropped or duplicated.
REQ-022: Simultaneous input and output transfer (0 < count < DEPTH) SHALL leave count unchanged, dequeue the head and enqueue the new value at the tail.
REQ-023: Full (count==DEPTH): in_rdy=0; in_val SHALL be ignored; output transfer SHALL decrement count.
REQ-024: Empty (count==0): out_rdy SHALL be ignored; input transfer SHALL set count to 1.
REQ-025: Read/write pointers SHALL wrap from DEPTH-1 to 0; correct for non-power-of-two DEPTH.
REQ-026: count SHALL be incremented on input-only transfer, decremented on output-only transfer, unchanged otherwise.
REQ-027: The design SHALL be free of latches and of combinational loops between in_rdy/in_val and out_val/out_rdy.

Reset
REQ-028: reset==0 at a rising edge SHALL set count=0 and both pointers to 0, discarding all entries; following the edge out_val=0, out=0, in_rdy=1.
REQ-029: Reset SHALL take priority over any simultaneous input or output transfer at the same edge.
REQ-030: Storage contents need not be cleared, but SHALL never be visible on out while count==0.

Verification (IN_NBITS=8, OUT_NBITS=32, DEPTH=2 unless stated)
REQ-031: Directed extend: enqueue 8'h7F mode1, 8'h80 mode1, 8'h80 mode0, 8'hFF mode1, draining each -> out 32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF in order, each one cycle after acceptance.
REQ-032: Fill/backpressure: out_rdy=0, offer 8'h01, 8'h02, 8'h03 mode0 -> first two accepted, count=2, in_rdy=0, 8'h03 held; then out_rdy=1 -> out 32'h1, 32'h2, then 32'h3 accepted and delivered.
REQ-033: Streaming: in_val=out_rdy=1 for 20 random values/modes -> count steady at 1 after first cycle, outputs match golden extension in order.
REQ-034: Reset mid-operation: with count=2 (8'hAA mode1, 8'h55 mode0), assert reset=0 for one edge with in_val=1 -> count=0, out_val=0, out=0, in_rdy=1, nothing enqueued.
REQ-035: Wrap-around with DEPTH=3: 10 enqueue/dequeue rounds with random out_rdy stalls -> FIFO order preserved, count never exceeds 3.
REQ-036: Width corner IN_NBITS=OUT_NBITS=8: 8'h80 mode1 and mode0 -> out 8'h80 both.

Source files
------------

// File: rtl/sext_queue.sv
// sext_queue: zero/sign-extends each accepted input word and holds the results
// in a small FIFO. Outputs are registered; there is no path from in_ to out.
module sext_queue #(
  parameter int IN_NBITS  = 8,
  parameter int OUT_NBITS = 32,
  parameter int DEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_val,
  output logic                         in_rdy,
  input  logic [IN_NBITS-1:0]          in_,
  input  logic                         in_mode,
  output logic                         out_val,
  input  logic                         out_rdy,
  output logic [OUT_NBITS-1:0]         out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0]     DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]     LAST_PTR  = PTR_W'(DEPTH - 1);
  // Bits above the input width; all zero when the two widths match.
  localparam logic [OUT_NBITS-1:0] FILL_MASK = ~(OUT_NBITS'({IN_NBITS{1'b1}}));

  logic [OUT_NBITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [OUT_NBITS-1:0] ext_value;
  logic                 do_push;
  logic                 do_pop;

  // Handshake flags, the extended input word, and the head presented on out.
  always_comb begin
    in_rdy    = (count < DEPTH_C);
    out_val   = (count != '0);
    do_push   = in_val && in_rdy;
    do_pop    = out_val && out_rdy;
    ext_value = OUT_NBITS'(in_) | ((in_mode && in_[IN_NBITS-1]) ? FILL_MASK : '0);
    out       = out_val ? mem[rd_ptr] : '0;
  end

  // Storage is not cleared by reset; out is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem[wr_ptr] <= ext_value;
    end
  end

  // Pointers and occupancy; reset wins over any transfer on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sext_queue.sv
// tb_sext_queue: three sext_queue instances (8->32 depth 2, 8->32 depth 3,
// 8->8 depth 2) checked cycle by cycle against a queue-based reference model.
module tb_sext_queue;

  localparam int NI = 3;

  logic clk;
  logic rst_n;
  logic started;

  logic [NI-1:0] in_val_v;
  logic [NI-1:0] in_mode_v;
  logic [NI-1:0] out_rdy_v;
  logic [7:0]    in_d [NI];
  wire  [NI-1:0] rdy_vec;

  int checks;
  int errors;

  logic [7:0] dir_vals  [4];
  logic       dir_modes [4];
  longint unsigned dir_exp [4];
  longint unsigned stream_exp [$];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extension from arithmetic: negative inputs in sign mode gain
  // the weight of all bits between the input and output widths.
  function automatic longint unsigned refExt(int iw, int ow, longint unsigned v, bit m);
    if (m && v >= (64'd1 << (iw - 1)))
      return v + ((64'd1 << ow) - (64'd1 << iw));
    return v;
  endfunction

  task automatic checkOutput(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer one word to instance g and hold it until the DUT accepts it.
  task automatic applyStimulus(int g, logic [7:0] d, bit m);
    in_d[g]      = d;
    in_mode_v[g] = m;
    in_val_v[g]  = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rdy_vec[g]) begin
        @(posedge clk);
        #1;
        in_val_v[g] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("[TB] FAIL handshake_timeout inst=%0d actual=stalled required=accepted", g);
    in_val_v[g] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : u
    localparam int IW = 8;
    localparam int OW = (g == 2) ? 8 : 32;
    localparam int DP = (g == 1) ? 3 : 2;

    logic                        in_rdy_w;
    logic                        out_val_w;
    logic [OW-1:0]               out_w;
    logic [$clog2(DP+1)-1:0]     count_w;
    longint unsigned             exp_q [$];
    longint unsigned             got_q [$];

    sext_queue #(.IN_NBITS(IW), .OUT_NBITS(OW), .DEPTH(DP)) dut (
      .clk     (clk),
      .reset   (rst_n),
      .in_val  (in_val_v[g]),
      .in_rdy  (in_rdy_w),
      .in_     (in_d[g]),
      .in_mode (in_mode_v[g]),
      .out_val (out_val_w),
      .out_rdy (out_rdy_v[g]),
      .out     (out_w),
      .count   (count_w)
    );

    assign rdy_vec[g] = in_rdy_w;

    // Reference model: a plain queue updated with the handshakes of this edge.
    always @(posedge clk) begin
      bit acc_in;
      bit acc_out;
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        acc_out = (exp_q.size() > 0) && out_rdy_v[g];
        acc_in  = in_val_v[g] && (exp_q.size() < DP);
        if (acc_out) void'(exp_q.pop_front());
        if (acc_in) exp_q.push_back(refExt(IW, OW, longint'(in_d[g]), in_mode_v[g]));
      end
    end

    // Monitor: compare visible state to the model, log delivered words.
    always @(negedge clk) begin
      if (started) begin
        checkOutput($sformatf("u%0d.count", g), 64'(count_w), 64'(exp_q.size()));
        checkOutput($sformatf("u%0d.in_rdy", g), 64'(in_rdy_w), 64'(exp_q.size() < DP));
        checkOutput($sformatf("u%0d.out_val", g), 64'(out_val_w), 64'(exp_q.size() != 0));
        checkOutput($sformatf("u%0d.out", g), 64'(out_w), (exp_q.size() != 0) ? exp_q[0] : 64'd0);
        if (out_val_w && out_rdy_v[g] && rst_n) got_q.push_back(64'(out_w));
      end
    end
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence of directed and random phases.
  initial begin
    checks     = 0;
    errors     = 0;
    started    = 1'b0;
    rst_n      = 1'b0;
    in_val_v   = '0;
    in_mode_v  = '0;
    out_rdy_v  = '0;
    for (int i = 0; i < NI; i++) in_d[i] = 8'h00;
    dir_vals  = '{8'h7F, 8'h80, 8'h80, 8'hFF};
    dir_modes = '{1'b1, 1'b1, 1'b0, 1'b1};
    dir_exp   = '{64'h0000007F, 64'hFFFFFF80, 64'h00000080, 64'hFFFFFFFF};

    @(posedge clk);
    #1;
    started = 1'b1;
    idle(1);
    rst_n = 1'b1;

    @(negedge clk);
    checkOutput("reset.count", 64'(u[0].count_w), 0);
    checkOutput("reset.out_val", 64'(u[0].out_val_w), 0);
    checkOutput("reset.in_rdy", 64'(u[0].in_rdy_w), 1);
    @(posedge clk);
    #1;

    // Directed extension values, one at a time with the consumer ready.
    $display("[TB] directed extend");
    out_rdy_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, dir_vals[i], dir_modes[i]);
      idle(1);
    end
    idle(2);
    checkOutput("extend.n", 64'(u[0].got_q.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < u[0].got_q.size())
        checkOutput($sformatf("extend.v%0d", i), u[0].got_q[i], dir_exp[i]);

    // Fill until full, hold the third word under backpressure, then drain.
    $display("[TB] fill and backpressure");
    u[0].got_q.delete();
    out_rdy_v[0] = 1'b0;
    applyStimulus(0, 8'h01, 1'b0);
    applyStimulus(0, 8'h02, 1'b0);
    in_d[0] = 8'h03;
    in_mode_v[0] = 1'b0;
    in_val_v[0] = 1'b1;
    idle(2);
    @(negedge clk);
    checkOutput("fill.count", 64'(u[0].count_w), 2);
    checkOutput("fill.in_rdy", 64'(u[0].in_rdy_w), 0);
    checkOutput("fill.head", 64'(u[0].out_w), 64'h1);
    @(posedge clk);
    #1;
    out_rdy_v[0] = 1'b1;
    applyStimulus(0, 8'h03, 1'b0);
    idle(3);
    checkOutput("fill.n", 64'(u[0].got_q.size()), 3);
    for (int i = 0; i < 3; i++)
      if (i < u[0].got_q.size())
        checkOutput($sformatf("fill.v%0d", i), u[0].got_q[i], 64'(i + 1));

    // Streaming: a new word every cycle with the consumer always ready.
    $display("[TB] streaming");
    u[0].got_q.delete();
    stream_exp.delete();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      bit m;
      d = 8'($urandom);
      m = 1'($urandom_range(0, 1));
      stream_exp.push_back(refExt(8, 32, longint'(d), m));
      applyStimulus(0, d, m);
    end
    idle(3);
    checkOutput("stream.n", 64'(u[0].got_q.size()), 20);
    for (int i = 0; i < 20; i++)
      if (i < u[0].got_q.size())
        checkOutput($sformatf("stream.v%0d", i), u[0].got_q[i], stream_exp[i]);

    // Reset while full and while a new word is offered.
    $display("[TB] reset mid-operation");
    out_rdy_v[0] = 1'b0;
    applyStimulus(0, 8'hAA, 1'b1);
    applyStimulus(0, 8'h55, 1'b0);
    @(negedge clk);
    checkOutput("rst.pre_count", 64'(u[0].count_w), 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_d[0] = 8'h33;
    in_val_v[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_val_v[0] = 1'b0;
    @(negedge clk);
    checkOutput("rst.count", 64'(u[0].count_w), 0);
    checkOutput("rst.out_val", 64'(u[0].out_val_w), 0);
    checkOutput("rst.out", 64'(u[0].out_w), 0);
    checkOutput("rst.in_rdy", 64'(u[0].in_rdy_w), 1);
    @(posedge clk);
    #1;

    // Depth-3 instance: random traffic and stalls to exercise pointer wrap.
    $display("[TB] wrap-around depth 3");
    for (int i = 0; i < 60; i++) begin
      in_val_v[1]  = 1'($urandom_range(0, 1));
      in_d[1]      = 8'($urandom);
      in_mode_v[1] = 1'($urandom_range(0, 1));
      out_rdy_v[1] = ($urandom_range(0, 3) != 0);
      idle(1);
      if (u[1].count_w > 2'd3)
        checkOutput("wrap.count_le3", 64'(u[1].count_w), 3);
    end
    in_val_v[1]  = 1'b0;
    out_rdy_v[1] = 1'b1;
    idle(4);
    @(negedge clk);
    checkOutput("wrap.drained", 64'(u[1].count_w), 0);
    @(posedge clk);
    #1;

    // Equal widths: the word passes through unchanged in both modes.
    $display("[TB] equal widths");
    u[2].got_q.delete();
    out_rdy_v[2] = 1'b1;
    applyStimulus(2, 8'h80, 1'b1);
    applyStimulus(2, 8'h80, 1'b0);
    idle(3);
    checkOutput("eq.n", 64'(u[2].got_q.size()), 2);
    for (int i = 0; i < 2; i++)
      if (i < u[2].got_q.size())
        checkOutput($sformatf("eq.v%0d", i), u[2].got_q[i], 64'h80);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
